// File: rtl/sqrt_seq_param.sv
// Sequential digit-by-digit integer square root: one root bit per enabled cycle,
// optional round-to-nearest with saturation, remainder and exact flags.
//
// Handshakes: a transfer happens on a rising edge where enable=1 and both valid
// and ready are high. in_ready is high only in IDLE. out_valid is high only in
// DONE and its payload (dout/rem/exact/sat) is stable until out_ready is taken.
module sqrt_seq_param #(
    parameter int DIN_W = 32,
    parameter int RT_W  = DIN_W / 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIN_W-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             round_en,
    output logic [RT_W-1:0]  dout,
    output logic [RT_W:0]    rem,
    output logic             exact,
    output logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       cstate
);

    localparam int CNT_W = (RT_W > 1) ? $clog2(RT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [DIN_W-1:0]  operand, operand_n;
    logic [RT_W+1:0]   r, r_n;
    logic [RT_W-1:0]   root, root_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              rnd, rnd_n;
    logic [RT_W-1:0]   dout_q, dout_n;
    logic [RT_W:0]     rem_q, rem_n;
    logic              exact_q, exact_n;
    logic              sat_q, sat_n;

    // One iteration of the restoring square-root recurrence.
    logic [RT_W+1:0]   r_sh, trial, r_step;
    logic [RT_W-1:0]   root_step;
    logic              ge;

    // Step datapath, next-state and output-register updates.
    always_comb begin
        state_n   = state;
        operand_n = operand;
        r_n       = r;
        root_n    = root;
        cnt_n     = cnt;
        rnd_n     = rnd;
        dout_n    = dout_q;
        rem_n     = rem_q;
        exact_n   = exact_q;
        sat_n     = sat_q;

        r_sh      = (r << 2) | {{RT_W{1'b0}}, operand[DIN_W-1:DIN_W-2]};
        trial     = {root, 2'b01};
        ge        = (r_sh >= trial);
        r_step    = ge ? (r_sh - trial) : r_sh;
        root_step = (root << 1) | {{(RT_W-1){1'b0}}, ge};

        case (state)
            IDLE: begin
                if (in_valid) begin
                    operand_n = din;
                    rnd_n     = round_en;
                    r_n       = '0;
                    root_n    = '0;
                    cnt_n     = CNT_MAX;
                    state_n   = CALC;
                end
            end
            CALC: begin
                operand_n = operand << 2;
                r_n       = r_step;
                root_n    = root_step;
                if (cnt == '0) begin
                    state_n = DONE;
                    rem_n   = r_step[RT_W:0];
                    exact_n = (r_step == '0);
                    sat_n   = 1'b0;
                    dout_n  = root_step;
                    // Round up when the remainder exceeds the root, i.e. din > (root+0.5)^2.
                    if (rnd && (r_step > {2'b00, root_step})) begin
                        if (&root_step) begin
                            dout_n = '1;
                            sat_n  = 1'b1;
                        end else begin
                            dout_n = root_step + 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // All state advances only on enabled edges; reset overrides enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            operand <= '0;
            r       <= '0;
            root    <= '0;
            cnt     <= '0;
            rnd     <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            exact_q <= 1'b0;
            sat_q   <= 1'b0;
        end else if (enable) begin
            state   <= state_n;
            operand <= operand_n;
            r       <= r_n;
            root    <= root_n;
            cnt     <= cnt_n;
            rnd     <= rnd_n;
            dout_q  <= dout_n;
            rem_q   <= rem_n;
            exact_q <= exact_n;
            sat_q   <= sat_n;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dout      = dout_q;
    assign rem       = rem_q;
    assign exact     = exact_q;
    assign sat       = sat_q;
    assign cstate    = state;

endmodule

// File: tb/tb_sqrt_seq_param.sv
// Directed bench for sqrt_seq_param (DIN_W=32): arithmetic reference model,
// expected-result queue, per-cycle output compare, and a final report.
module tb_sqrt_seq_param;

    localparam int DIN_W = 32;
    localparam int RT_W  = 16;
    localparam int EW    = RT_W + (RT_W + 1) + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [DIN_W-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic             round_en;
    logic [RT_W-1:0]  dout;
    logic [RT_W:0]    rem;
    logic             exact;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       cstate;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    sqrt_seq_param #(.DIN_W(DIN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .round_en  (round_en),
        .dout      (dout),
        .rem       (rem),
        .exact     (exact),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cstate    (cstate)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Reference: largest x with x*x <= d by binary search; round up when d - x*x > x.
    function automatic logic [EW-1:0] model(input logic [DIN_W-1:0] d, input logic rnd);
        longint unsigned lo, hi, mid, rm, dv;
        logic [RT_W-1:0] o_d;
        logic o_s;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(d)) lo = mid;
            else hi = mid - 1;
        end
        rm  = longint'(d) - lo * lo;
        dv  = lo;
        o_s = 1'b0;
        if (rnd && rm > lo) begin
            if (lo == 65535) o_s = 1'b1;
            else dv = lo + 1;
        end
        o_d = dv[RT_W-1:0];
        return {o_d, rm[RT_W:0], (rm == 0), o_s};
    endfunction

    // Compare process: whenever a result is presented it must match the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {dout, rem, exact, sat}, '0);
            end else begin
                check("result", {dout, rem, exact, sat}, exp_q[0]);
                if (out_ready && enable) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: present one operand for one edge (unit must be idle); pin the model on literals.
    task automatic send(input logic [DIN_W-1:0] d, input logic rnd,
                        input int e_d, input int e_r, input logic e_x, input logic e_s);
        logic [EW-1:0] m;
        m = model(d, rnd);
        check("model_dout", m[EW-1 -: RT_W], e_d);
        check("model_rem", m[RT_W+2:2], e_r);
        check("model_flags", m[1:0], {e_x, e_s});
        check("in_ready_before_send", in_ready, 1'b1);
        exp_q.push_back(m);
        din      = d;
        round_en = rnd;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        round_en = 1'b0;
    endtask

    // Driver: wait for the result (bounded), hold backpressure, then complete it.
    task automatic wait_result(input int lit_dout, input int hold, input int exp_lat, input int pre);
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k + pre, exp_lat);
        check("dout_literal", dout, lit_dout);
        for (int i = 0; i < hold; i++) begin
            check("in_ready_in_done", in_ready, 1'b0);
            if (i == 2) begin
                din      = 32'd7;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_cleared", out_valid, 1'b0);
        check("in_ready_idle", in_ready, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        din       = '0;
        in_valid  = 1'b0;
        round_en  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {cstate, in_ready, out_valid, dout, rem, exact, sat},
              {2'd0, 1'b1, 1'b0, 16'd0, 17'd0, 1'b0, 1'b0});
        reset = 1'b0;
        @(posedge clk);
        #1;

        send(32'd0, 1'b0, 0, 0, 1'b1, 1'b0);           wait_result(0, 0, 16, 0);
        send(32'd1000000, 1'b0, 1000, 0, 1'b1, 1'b0);  wait_result(1000, 0, 16, 0);
        send(32'd999999, 1'b0, 999, 1998, 1'b0, 1'b0); wait_result(999, 0, 16, 0);
        send(32'd2, 1'b1, 1, 1, 1'b0, 1'b0);           wait_result(1, 0, 16, 0);
        send(32'd3, 1'b1, 2, 2, 1'b0, 1'b0);           wait_result(2, 0, 16, 0);
        send(32'd15, 1'b1, 4, 6, 1'b0, 1'b0);          wait_result(4, 0, 16, 0);
        send(32'hFFFFFFFF, 1'b0, 65535, 131070, 1'b0, 1'b0); wait_result(65535, 0, 16, 0);
        send(32'hFFFFFFFF, 1'b1, 65535, 131070, 1'b0, 1'b1); wait_result(65535, 0, 16, 0);
        send(32'hFFFE0001, 1'b0, 65535, 0, 1'b1, 1'b0); wait_result(65535, 0, 16, 0);

        // Backpressure: hold 5 cycles with a stray in_valid pulse, then a fresh operand.
        send(32'd1000000, 1'b0, 1000, 0, 1'b1, 1'b0);  wait_result(1000, 5, 16, 0);
        send(32'd144, 1'b0, 12, 0, 1'b1, 1'b0);        wait_result(12, 0, 16, 0);

        // Reset in the middle of CALC aborts the operation.
        send(32'd50000, 1'b0, 223, 271, 1'b0, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("calc_before_abort", cstate, 2'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(exp_q.pop_back());
        check("abort_state", {cstate, in_ready, out_valid}, {2'd0, 1'b1, 1'b0});
        send(32'd81, 1'b0, 9, 0, 1'b1, 1'b0);          wait_result(9, 0, 16, 0);

        // Enable low for 3 cycles mid-CALC stretches latency by 3.
        send(32'd999999, 1'b1, 1000, 1998, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("frozen_calc", {cstate, out_valid}, {2'd1, 1'b0});
        end
        enable = 1'b1;
        wait_result(1000, 0, 19, 8);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
